// File: rtl/r_issue_stage_pkg.sv
// Shared core definitions: R-type encodings, instruction field positions
// and the payload carried from issue to the R-type ALU.
package r_issue_stage_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    // func3 values that have an F7_ALT form (sub, sra)
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    // Instruction field bit positions
    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;
    localparam int F7_LSB  = 25;
    localparam int F7_MSB  = 31;
    localparam int TH_BIT  = 30;

    typedef struct packed {
        logic [2:0]  func3;
        logic        bit_th;
        logic [31:0] operator1;
        logic [31:0] operator2;
        logic [4:0]  rd;
        logic        illegal;
    } issue_payload_t;

    // True when the word is an R-type the ALU implements.
    function automatic logic is_legal_rtype(input logic [31:0] ins);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = ins[F7_MSB:F7_LSB];
        f3 = ins[F3_MSB:F3_LSB];
        return (ins[OPC_MSB:OPC_LSB] == OP_RTYPE) &&
               ((f7 == F7_BASE) ||
                ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA))));
    endfunction

endpackage

// File: rtl/r_issue_stage_fwd_mux.sv
// Operand forwarding for one source register: EX/MEM beats MEM/WB beats
// the register file; x0 always reads as zero.
module fwd_mux
    import r_issue_stage_pkg::*;
(
    input  logic [4:0]  rs_addr,
    input  logic [31:0] rf_data,
    input  logic        exmem_wen,
    input  logic        exmem_load,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_data,
    input  logic        memwb_wen,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_data,
    output logic [31:0] fwd_data
);

    // Priority select; a load in EX/MEM has no data yet, so it never forwards
    // (the issue stage stalls on that case instead).
    always_comb begin
        fwd_data = rf_data;
        if (rs_addr == 5'd0) begin
            fwd_data = '0;
        end else if (exmem_wen && !exmem_load && (exmem_rd == rs_addr)) begin
            fwd_data = exmem_data;
        end else if (memwb_wen && (memwb_rd == rs_addr)) begin
            fwd_data = memwb_data;
        end
    end

endmodule

// File: rtl/r_issue_stage.sv
// R-type issue stage: one-entry valid/ready register slice that captures
// forwarded operands and decoded fields, stalls on load-use and honours flush.
module r_issue_stage
    import r_issue_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        exmem_wen,
    input  logic        exmem_load,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_data,
    input  logic        memwb_wen,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  func3,
    output logic        bit_th,
    output logic [31:0] operator1,
    output logic [31:0] operator2,
    output logic [4:0]  rd,
    output logic        illegal
);

    logic           valid_q, valid_d;
    issue_payload_t payload_q, payload_d;

    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] fwd1_data, fwd2_data;
    logic        hazard;
    logic        take_in, take_out;

    assign rs1_addr = instr[RS1_MSB:RS1_LSB];
    assign rs2_addr = instr[RS2_MSB:RS2_LSB];

    fwd_mux u_fwd_rs1 (
        .rs_addr    (rs1_addr),
        .rf_data    (rs1_data),
        .exmem_wen  (exmem_wen),
        .exmem_load (exmem_load),
        .exmem_rd   (exmem_rd),
        .exmem_data (exmem_data),
        .memwb_wen  (memwb_wen),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_data),
        .fwd_data   (fwd1_data)
    );

    fwd_mux u_fwd_rs2 (
        .rs_addr    (rs2_addr),
        .rf_data    (rs2_data),
        .exmem_wen  (exmem_wen),
        .exmem_load (exmem_load),
        .exmem_rd   (exmem_rd),
        .exmem_data (exmem_data),
        .memwb_wen  (memwb_wen),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_data),
        .fwd_data   (fwd2_data)
    );

    // Load-use: the value an operand needs is still in flight from memory.
    assign hazard = in_valid && exmem_load && exmem_wen && (exmem_rd != 5'd0) &&
                    ((exmem_rd == rs1_addr) || (exmem_rd == rs2_addr));

    // Flush is folded into in_ready so the upstream stage never sees a
    // handshake that the stage then drops.
    assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
    assign take_in  = in_valid && in_ready;
    assign take_out = valid_q && out_ready;

    // Next-state: flush wins, then a new acceptance, then a plain drain;
    // payload only moves on acceptance.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (take_in) begin
            valid_d = 1'b1;
        end else if (take_out) begin
            valid_d = 1'b0;
        end
        if (take_in) begin
            payload_d.func3     = instr[F3_MSB:F3_LSB];
            payload_d.bit_th    = instr[TH_BIT];
            payload_d.operator1 = fwd1_data;
            payload_d.operator2 = fwd2_data;
            payload_d.illegal   = !is_legal_rtype(instr);
            payload_d.rd        = is_legal_rtype(instr) ? instr[RD_MSB:RD_LSB] : 5'd0;
        end
    end

    // State registers, cleared asynchronously so outputs drop without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign out_valid = valid_q;
    assign func3     = payload_q.func3;
    assign bit_th    = payload_q.bit_th;
    assign operator1 = payload_q.operator1;
    assign operator2 = payload_q.operator2;
    assign rd        = payload_q.rd;
    assign illegal   = payload_q.illegal;

endmodule

// File: tb/tb_r_issue_stage.sv
// Bench for r_issue_stage: directed scenarios plus random traffic, with a
// queue of expected payloads drained by an independent output monitor.
module tb_r_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        exmem_wen;
    logic        exmem_load;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_data;
    logic        memwb_wen;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  func3;
    logic        bit_th;
    logic [31:0] operator1;
    logic [31:0] operator2;
    logic [4:0]  rd;
    logic        illegal;

    typedef struct {
        logic [2:0]  f3;
        logic        th;
        logic [31:0] o1;
        logic [31:0] o2;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    bit   model_valid = 1'b0;
    int   checks = 0;
    int   errors = 0;

    r_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .exmem_wen  (exmem_wen),
        .exmem_load (exmem_load),
        .exmem_rd   (exmem_rd),
        .exmem_data (exmem_data),
        .memwb_wen  (memwb_wen),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .func3      (func3),
        .bit_th     (bit_th),
        .operator1  (operator1),
        .operator2  (operator2),
        .rd         (rd),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] fwd_ref(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return 32'd0;
        if (exmem_wen && !exmem_load && exmem_rd == rs) return exmem_data;
        if (memwb_wen && memwb_rd == rs) return memwb_data;
        return rf;
    endfunction

    function automatic exp_t ref_payload();
        exp_t e;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       legal;
        f7 = instr[31:25];
        f3 = instr[14:12];
        legal = (instr[6:0] == 7'h33) &&
                (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        e.f3  = f3;
        e.th  = instr[30];
        e.o1  = fwd_ref(instr[19:15], rs1_data);
        e.o2  = fwd_ref(instr[24:20], rs2_data);
        e.ill = !legal;
        e.rd  = legal ? instr[11:7] : 5'd0;
        return e;
    endfunction

    function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rdn);
        return {f7, rs2, rs1, f3, rdn, 7'h33};
    endfunction

    // Output monitor: every output transfer must match the oldest expected payload.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("func3", {29'd0, func3}, {29'd0, e.f3});
                chk("bit_th", {31'd0, bit_th}, {31'd0, e.th});
                chk("operator1", operator1, e.o1);
                chk("operator2", operator2, e.o2);
                chk("rd", {27'd0, rd}, {27'd0, e.rd});
                chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
                $display("xfer t=%0t f3=%0d th=%0b op1=%08h op2=%08h rd=%0d ill=%0b",
                         $time, func3, bit_th, operator1, operator2, rd, illegal);
            end
        end
    end

    // One clock of stimulus: check handshake against the model between edges,
    // record acceptances, then advance to just after the next rising edge.
    task automatic step();
        logic hz_m, rdy_m, oxfer, acc;
        @(negedge clk);
        #1;
        hz_m  = in_valid && exmem_load && exmem_wen && exmem_rd != 5'd0 &&
                (exmem_rd == instr[19:15] || exmem_rd == instr[24:20]);
        rdy_m = (!model_valid || out_ready) && !hz_m && !flush;
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_m});
        chk("out_valid", {31'd0, out_valid}, {31'd0, model_valid});
        oxfer = model_valid && out_ready;
        if (flush && model_valid && !out_ready && exp_q.size() > 0) exp_q.delete(0);
        acc = in_valid && rdy_m;
        if (acc) exp_q.push_back(ref_payload());
        if (flush)      model_valid = 1'b0;
        else if (acc)   model_valid = 1'b1;
        else if (oxfer) model_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_fwd();
        exmem_wen = 0; exmem_load = 0; exmem_rd = 0; exmem_data = 0;
        memwb_wen = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    logic [31:0] snap_op1;
    logic [4:0]  snap_rd;

    initial begin
        rst_n = 0; in_valid = 0; instr = 0; rs1_data = 0; rs2_data = 0;
        flush = 0; out_ready = 0;
        quiet_fwd();
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_operator1", operator1, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;

        // Scenario 1: add x3,x1,x2 with x1 forwarded from EX/MEM
        instr = mk_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
        rs1_data = 32'd100; rs2_data = 32'd7;
        exmem_wen = 1; exmem_rd = 1; exmem_data = 32'd5;
        in_valid = 1; out_ready = 1;
        step();
        in_valid = 0;
        chk("s1_out_valid", {31'd0, out_valid}, 32'd1);
        chk("s1_operator1", operator1, 32'd5);
        chk("s1_operator2", operator2, 32'd7);
        chk("s1_rd", {27'd0, rd}, 32'd3);
        chk("s1_bit_th", {31'd0, bit_th}, 32'd0);

        // Scenario 2: sub x4,x0,x2, EX/MEM beats MEM/WB, x0 reads zero
        instr = mk_r(7'h20, 5'd2, 5'd0, 3'd0, 5'd4);
        rs1_data = 32'd55;
        exmem_wen = 1; exmem_rd = 2; exmem_data = 32'd9;
        memwb_wen = 1; memwb_rd = 2; memwb_data = 32'd1;
        in_valid = 1;
        step();
        chk("s2_operator1", operator1, 32'd0);
        chk("s2_operator2", operator2, 32'd9);
        chk("s2_bit_th", {31'd0, bit_th}, 32'd1);

        // Scenario 3: load-use stall, then accept once the load retires
        quiet_fwd();
        instr = mk_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
        exmem_wen = 1; exmem_load = 1; exmem_rd = 1; exmem_data = 32'hdead;
        step();
        chk("s3_stalled", {31'd0, out_valid}, 32'd0);
        exmem_load = 0;
        step();
        chk("s3_accepted", {31'd0, out_valid}, 32'd1);

        // Scenario 4: backpressure holds outputs, then back-to-back flow
        quiet_fwd();
        out_ready = 0;
        instr = mk_r(7'h00, 5'd3, 5'd2, 3'd4, 5'd9);
        snap_op1 = operator1; snap_rd = rd;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s4_hold_op1", operator1, snap_op1);
            chk("s4_hold_rd", {27'd0, rd}, {27'd0, snap_rd});
        end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            instr = mk_r(7'h00, 5'(i + 1), 5'(i + 2), 3'(i), 5'(i + 10));
            rs1_data = $urandom; rs2_data = $urandom;
            step();
            chk("s4_stream_valid", {31'd0, out_valid}, 32'd1);
        end

        // Scenario 5: funct7 alt with func3 001 is illegal, rd forced to 0
        instr = mk_r(7'h20, 5'd2, 5'd1, 3'd1, 5'd7);
        step();
        chk("s5_illegal", {31'd0, illegal}, 32'd1);
        chk("s5_rd", {27'd0, rd}, 32'd0);

        // Scenario 6: flush under backpressure, then reset mid-stall
        out_ready = 0; flush = 1;
        step();
        flush = 0;
        chk("s6_flush_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1;
        instr = mk_r(7'h00, 5'd5, 5'd6, 3'd7, 5'd12);
        rs1_data = 32'h1234; rs2_data = 32'h5678;
        step();
        out_ready = 0;
        step();
        rst_n = 0;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_operator1", operator1, 32'd0);
        chk("rst_operator2", operator2, 32'd0);
        chk("rst_rd", {27'd0, rd}, 32'd0);
        chk("rst_func3", {29'd0, func3}, 32'd0);
        chk("rst_fields", {30'd0, bit_th, illegal}, 32'd0);
        exp_q.delete();
        model_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1;
        out_ready = 1; in_valid = 1;
        instr = mk_r(7'h00, 5'd1, 5'd2, 3'd6, 5'd13);
        step();
        chk("post_reset_accept", {31'd0, out_valid}, 32'd1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [6:0] f7;
            logic [6:0] opc;
            case ($urandom_range(0, 9))
                0:       f7 = 7'($urandom);
                1, 2:    f7 = 7'h20;
                default: f7 = 7'h00;
            endcase
            opc = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'h33;
            instr = {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     3'($urandom), 5'($urandom), opc};
            rs1_data   = $urandom;
            rs2_data   = $urandom;
            exmem_wen  = 1'($urandom);
            exmem_load = ($urandom_range(0, 3) == 0);
            exmem_rd   = 5'($urandom_range(0, 3));
            exmem_data = $urandom;
            memwb_wen  = 1'($urandom);
            memwb_rd   = 5'($urandom_range(0, 3));
            memwb_data = $urandom;
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            step();
        end

        // Drain and confirm nothing expected was left behind
        in_valid = 0; flush = 0; out_ready = 1;
        repeat (3) step();
        chk("drain_queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
